// File: rtl/pwm_mc.sv
// Multi-channel PWM: shared prescaled edge/center counter, per-channel double-buffered duty.
// Optional LFSR duty dither is enabled by defining PWM_MC_DITHER_EN.

module pwm_mc_ch #(
  parameter int PWM_BITS = 10
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  input  logic                hi_we,
  input  logic                lo_we,
  input  logic [7:0]          wdata,
  input  logic                load,
  input  logic                en,
  input  logic                mask,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic [7:0]          offset,
  output logic [PWM_BITS-1:0] shadow,
  output logic                pwm
);
  localparam int HW = PWM_BITS - 8;

  logic [HW-1:0]       stage;
  logic [PWM_BITS-1:0] active;
  logic [PWM_BITS:0]   cmp;

  // One extra bit so duty+offset never wraps below the counter.
  assign cmp = {1'b0, active} + {{(PWM_BITS-7){1'b0}}, offset};

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      stage  <= '0;
      shadow <= '0;
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      if (hi_we) stage  <= wdata[HW-1:0];
      if (lo_we) shadow <= {stage, wdata};
      if (load)  active <= shadow;
      pwm <= en & mask & ({1'b0, cnt} < cmp);
    end
  end
endmodule

module pwm_mc #(
  parameter int CHANNELS   = 4,
  parameter int PWM_BITS   = 10,
  parameter int PRESC_BITS = 8
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  input  logic [7:0]          b_addr_i,
  input  logic [7:0]          b_data_i,
  output logic [7:0]          b_data_o,
  input  logic                b_write_i,
  output logic [CHANNELS-1:0] pwm_o,
  output logic                period_o
);
  localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};

  logic                  ctl_en, ctl_center, status;
  logic [1:0]            ctl_ss;
  logic [PRESC_BITS-1:0] presc, psc_cnt;
  logic [CHANNELS-1:0]   ch_mask, hi_we, lo_we;
  logic [PWM_BITS-1:0]   cnt;
  logic                  dir_dn, center_act;
  logic                  tick, boundary, load;
  logic [7:0]            offset;
  logic [CHANNELS-1:0][PWM_BITS-1:0] shadow;

  logic w_ctl, w_psc, w_msk, w_sts;
  assign w_ctl = b_write_i && (b_addr_i == 8'h00);
  assign w_psc = b_write_i && (b_addr_i == 8'h01);
  assign w_msk = b_write_i && (b_addr_i == 8'h02);
  assign w_sts = b_write_i && (b_addr_i == 8'h03);

  assign tick     = ctl_en && (psc_cnt >= presc);
  assign boundary = tick && (center_act ? (cnt == '0 && dir_dn) : (cnt == MAX));
  // While disabled the active copies track the shadows so EN starts with fresh duties.
  assign load     = boundary | ~ctl_en;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      ctl_en     <= 1'b0;
      ctl_center <= 1'b0;
      presc      <= '0;
      ch_mask    <= '0;
      status     <= 1'b0;
      center_act <= 1'b0;
      period_o   <= 1'b0;
    end else begin
      if (w_ctl) begin
        ctl_en     <= b_data_i[7];
        ctl_center <= b_data_i[6];
      end
      if (w_psc) presc   <= b_data_i[PRESC_BITS-1:0];
      if (w_msk) ch_mask <= b_data_i[CHANNELS-1:0];
      status   <= boundary | (status & ~(w_sts & b_data_i[0]));
      if (load) center_act <= ctl_center;
      period_o <= boundary;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      psc_cnt <= '0;
      cnt     <= '0;
      dir_dn  <= 1'b0;
    end else if (!ctl_en) begin
      psc_cnt <= '0;
      cnt     <= '0;
      dir_dn  <= 1'b0;
    end else begin
      psc_cnt <= tick ? '0 : psc_cnt + PRESC_BITS'(1);
      if (tick) begin
        if (!center_act) begin
          cnt    <= cnt + PWM_BITS'(1);
          dir_dn <= 1'b0;
        end else if (!dir_dn) begin
          // Direction flips when leaving the end points, so 0 and MAX appear once per period.
          if (cnt == MAX) begin
            dir_dn <= 1'b1;
            cnt    <= cnt - PWM_BITS'(1);
          end else begin
            cnt <= cnt + PWM_BITS'(1);
          end
        end else if (cnt == '0) begin
          dir_dn <= 1'b0;
          cnt    <= cnt + PWM_BITS'(1);
        end else begin
          cnt <= cnt - PWM_BITS'(1);
        end
      end
    end
  end

`ifdef PWM_MC_DITHER_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      ctl_ss <= 2'b00;
      lfsr   <= 8'hFF;
    end else begin
      if (w_ctl) ctl_ss <= b_data_i[1:0];
      if (boundary && ctl_ss != 2'b00)
        lfsr <= {lfsr[6], lfsr[5], lfsr[4], lfsr[3] ^ lfsr[7],
                 lfsr[2] ^ lfsr[7], lfsr[1] ^ lfsr[7], lfsr[0], lfsr[7]};
    end
  end

  always_comb begin
    offset = '0;
    case (ctl_ss)
      2'b01:   offset = lfsr >> 5;
      2'b10:   offset = lfsr >> 3;
      2'b11:   offset = lfsr >> 1;
      default: offset = '0;
    endcase
  end
`else
  assign ctl_ss = 2'b00;
  assign offset = '0;
`endif

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    assign hi_we[n] = b_write_i && (b_addr_i == 8'(16 + 2*n));
    assign lo_we[n] = b_write_i && (b_addr_i == 8'(17 + 2*n));

    pwm_mc_ch #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk_i  (clk_i),
      .nrst_i (nrst_i),
      .hi_we  (hi_we[n]),
      .lo_we  (lo_we[n]),
      .wdata  (b_data_i),
      .load   (load),
      .en     (ctl_en),
      .mask   (ch_mask[n]),
      .cnt    (cnt),
      .offset (offset),
      .shadow (shadow[n]),
      .pwm    (pwm_o[n])
    );
  end

  always_comb begin
    b_data_o = 8'h00;
    case (b_addr_i)
      8'h00:   b_data_o = {ctl_en, ctl_center, 4'b0000, ctl_ss};
      8'h01:   b_data_o = 8'(presc);
      8'h02:   b_data_o = 8'(ch_mask);
      8'h03:   b_data_o = {7'b0, status};
      default: b_data_o = 8'h00;
    endcase
    for (int n = 0; n < CHANNELS; n++) begin
      if (b_addr_i == 8'(16 + 2*n)) b_data_o = 8'(shadow[n][PWM_BITS-1:8]);
      if (b_addr_i == 8'(17 + 2*n)) b_data_o = shadow[n][7:0];
    end
  end
endmodule

// File: tb/tb_pwm_mc.sv
// Directed bench for pwm_mc: register map, edge/center timing, double buffering, bounds.
module tb_pwm_mc;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [7:0]    addr = '0, wd = '0, rd;
  logic          wr_s = 1'b0;
  logic [CH-1:0] pwm;
  logic          per;

  int checks = 0, errors = 0;
  int mch = 0, acc_hi = 0, acc_per = 0, last_hi = 0, last_per = 0, nper = 0;

  always #5 clk = ~clk;

  pwm_mc #(.CHANNELS(CH), .PWM_BITS(10), .PRESC_BITS(8)) dut (
    .clk_i(clk), .nrst_i(nrst), .b_addr_i(addr), .b_data_i(wd), .b_data_o(rd),
    .b_write_i(wr_s), .pwm_o(pwm), .period_o(per)
  );

  // Per-period high/length of the watched channel; closes on each period_o sample.
  always @(negedge clk) begin
    if (per) begin
      last_hi  <= acc_hi + int'(pwm[mch]);
      last_per <= acc_per + 1;
      acc_hi   <= 0;
      acc_per  <= 0;
      nper     <= nper + 1;
    end else begin
      acc_hi  <= acc_hi + int'(pwm[mch]);
      acc_per <= acc_per + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; wd = d; wr_s = 1'b1;
    @(negedge clk);
    wr_s = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [7:0] a, input int exp);
    addr = a;
    #1;
    chk(tag, int'(rd), exp);
  endtask

  task automatic wait_per(input int k);
    int n0, t;
    n0 = nper; t = 0;
    while (nper < n0 + k && t < 20000) begin
      @(negedge clk); #1; t++;
    end
    if (nper < n0 + k) begin
      checks++; errors++;
      $error("FAIL period_timeout observed=%0d expected=%0d", nper - n0, k);
    end
  endtask

  initial begin
    int hi, len;
    logic [7:0] regs [6];
    regs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_period", int'(per), 0);
    foreach (regs[i]) rdchk($sformatf("rst_reg%0h", regs[i]), regs[i], 0);
    nrst = 1'b1;
    @(negedge clk);

    // Register readback and unmapped space
    wr(8'h00, 8'h43);
`ifdef PWM_MC_DITHER_EN
    rdchk("ctl_rb", 8'h00, 8'h43);
`else
    rdchk("ctl_rb", 8'h00, 8'h40);
`endif
    wr(8'h00, 8'h00);
    wr(8'h18, 8'hFF);
    rdchk("unmapped18", 8'h18, 0);
    rdchk("unmapped04", 8'h04, 0);

    // Edge mode, duty 0x100
    wr(8'h02, 8'h01);
    wr(8'h10, 8'h01);
    wr(8'h11, 8'h00);
    rdchk("duty0_hi", 8'h10, 1);
    rdchk("duty0_lo", 8'h11, 0);
    wr(8'h00, 8'h80);
    wait_per(2);
    chk("edge_hi", last_hi, 256);
    chk("edge_per", last_per, 1024);

    // Mid-period duty change lands one period later; HI-only write never lands
    repeat (50) @(negedge clk);
    wr(8'h10, 8'h02);
    wr(8'h11, 8'h00);
    rdchk("shadow_hi", 8'h10, 2);
    wait_per(1);
    chk("shadow_cur", last_hi, 256);
    wait_per(1);
    chk("shadow_next", last_hi, 512);
    wr(8'h10, 8'h01);
    wait_per(2);
    chk("hi_only_pwm", last_hi, 512);
    rdchk("hi_only_rd", 8'h10, 2);

    // Duty bounds
    wr(8'h10, 8'h00);
    wr(8'h11, 8'h00);
    wait_per(2);
    chk("duty0_hi_cnt", last_hi, 0);
    wr(8'h10, 8'h03);
    wr(8'h11, 8'hFF);
    wait_per(2);
    chk("dutymax_hi", last_hi, 1023);
    chk("dutymax_per", last_per, 1024);

    // STATUS W1C: clears mid-period, set wins on the boundary clock
    wait_per(1);
    repeat (500) @(negedge clk);
    wr(8'h03, 8'h01);
    rdchk("sts_clr", 8'h03, 0);
    repeat (522) @(negedge clk);
    wr(8'h03, 8'h01);
    rdchk("sts_setwins", 8'h03, 1);
    chk("period_pulse", int'(per), 1);
    @(negedge clk);
    chk("period_1clk", int'(per), 0);

    // EN 1->0 while high
    repeat (10) @(negedge clk);
    chk("pre_dis_hi", int'(pwm[0]), 1);
    wr(8'h00, 8'h00);
    @(negedge clk);
    chk("dis_low", int'(pwm[0]), 0);

    // Center mode on channel 1: state 0 is visited once per period, so width = 2*duty-1
    wr(8'h12, 8'h00);
    wr(8'h13, 8'h80);
    wr(8'h02, 8'h02);
    mch = 1;
    wr(8'h00, 8'h40);
    wr(8'h00, 8'hC0);
    wait_per(2);
    chk("ctr_hi", last_hi, 255);
    chk("ctr_per", last_per, 2046);
    chk("ctr_mask0", int'(pwm[0]), 0);
    wr(8'h01, 8'h03);
    wait_per(2);
    chk("ctr_psc_hi", last_hi, 1020);
    chk("ctr_psc_per", last_per, 8184);
    rdchk("presc_rb", 8'h01, 3);

    // Asynchronous reset mid-period
    repeat (100) @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("mid_rst_pwm", int'(pwm), 0);
    chk("mid_rst_per", int'(per), 0);
    rdchk("mid_rst_ctl", 8'h00, 0);
    rdchk("mid_rst_psc", 8'h01, 0);
    rdchk("mid_rst_msk", 8'h02, 0);
    rdchk("mid_rst_d1lo", 8'h13, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

`ifdef PWM_MC_DITHER_EN
    // Dither SS=11 from reset LFSR 0xFF: offsets 127 then 0xE3>>1=113
    mch = 0;
    wr(8'h02, 8'h01);
    wr(8'h10, 8'h01);
    wr(8'h11, 8'h00);
    wr(8'h00, 8'h83);
    hi = 0; len = 0;
    do begin
      @(negedge clk);
      len++;
      hi += int'(pwm[0]);
    end while (!per && len < 5000);
    chk("dith_first_hi", hi, 383);
    chk("dith_first_per", len, 1024);
    wait_per(1);
    chk("dith_second_hi", last_hi, 369);
`else
    hi = 0; len = 0;
    chk("nodith_idle", hi + len + int'(pwm), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
